// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: fill FSM encoding,
// default geometry and the address-width helper.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_rf_read_port.sv
// One combinational read port: array mux, write bypass, register-0 forcing
// and busy masking.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = addr_width(NREGS_DEF),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   run,
  input  logic [AW-1:0]          addr,
  input  logic [NREGS*XLEN-1:0]  rf_flat,
  input  logic [NREGS-1:0]       busy,
  input  logic                   we,
  input  logic [AW-1:0]          rd,
  input  logic [XLEN-1:0]        wdata,
  output logic [XLEN-1:0]        data,
  output logic                   busy_out
);

  logic zero_addr;
  logic zero_rd;
  logic hit;

  assign zero_addr = ZERO_REG && (addr == '0);
  assign zero_rd   = ZERO_REG && (rd == '0);
  assign hit       = BYPASS && we && (rd == addr) && !zero_rd;

  // A bypass hit means the producer is completing right now, so the operand
  // is no longer pending even though the busy bit clears only at the edge.
  always_comb begin
    data     = '0;
    busy_out = 1'b0;
    if (run && !zero_addr) begin
      data     = hit ? wdata : rf_flat[addr*XLEN +: XLEN];
      busy_out = hit ? 1'b0 : busy[addr];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write bypass, issue-stage busy scoreboard
// and a zero-fill sequencer that runs after reset and on soft clear.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                we,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     wdata,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd
);

  state_t            state;
  state_t            next_state;
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     next_ptr;
  logic [XLEN-1:0]   rf [NREGS];
  logic [NREGS*XLEN-1:0] rf_flat;
  logic [NREGS-1:0]  busy;
  logic              run;

  assign run   = (state == ST_RUN);
  assign ready = run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // A clear request during the fill restarts it from register 0.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      ST_INIT: begin
        if (clear_req) begin
          next_ptr = '0;
        end else begin
          next_ptr = ptr + 1'b1;
          if (ptr == AW'(NREGS - 1)) next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          next_state = ST_INIT;
          next_ptr   = '0;
        end
      end
      default: begin
        next_state = ST_INIT;
        next_ptr   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      rf[ptr] <= '0;
    end else if (we && !(ZERO_REG && (rd == '0))) begin
      rf[rd] <= wdata;
    end
  end

  // Set is applied after clear so a same-register issue supersedes writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (!run || clear_req) begin
      busy <= '0;
    end else begin
      if (we) busy[rd] <= 1'b0;
      if (issue_valid && !(ZERO_REG && (issue_rd == '0))) busy[issue_rd] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign rf_flat[g*XLEN +: XLEN] = rf[g];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    rf_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .AW       (AW),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .run      (run),
      .addr     (rs_addr[p*AW +: AW]),
      .rf_flat  (rf_flat),
      .busy     (busy),
      .we       (we),
      .rd       (rd),
      .wdata    (wdata),
      .data     (rs_data[p*XLEN +: XLEN]),
      .busy_out (rs_busy[p])
    );
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write, two-read integer register file. It adds:
- a configurable number of read ports, word width and register count;
- optional write-to-read bypass;
- a per-register busy scoreboard for the issue stage;
- a hardware zero-fill sequencer that runs after reset and on soft-clear requests.

It sits between decode/issue and writeback in the core pipeline.

Parameters:
XLEN, 32, data word width in bits
NREGS, 32, number of architectural registers; power of two, at least 2
AW, $clog2(NREGS), register address width; derived, not overridden
NRD, 2, number of read ports, 1 to 4
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low (asserted when 0)
clear_req  in  1  synchronous soft clear; restarts the zero-fill
ready  out  1  1 = RUN state; reads, writes and issues are valid
rs_addr  in  NRD*AW  packed read addresses; port i is at [i*AW +: AW]
rs_data  out  NRD*XLEN  packed read data
rs_busy  out  NRD  1 = operand at port i has a pending producer
we  in  1  writeback enable
rd  in  AW  writeback address
wdata  in  XLEN  writeback data
issue_valid  in  1  an instruction with destination issue_rd issues this cycle
issue_rd  in  AW  destination register of the issuing instruction

Behaviour:
- Reset asserted (reset==0), taking effect immediately:
  - FSM goes to INIT, fill pointer = 0.
  - All busy bits = 0, ready = 0.
  - The storage array itself is not reset.
- FSM states: INIT and RUN.
- INIT, each cycle:
  - Writes 0 to RF[ptr], then ptr increments.
  - When ptr == NREGS-1 is written, the next state is RUN.
  - INIT therefore lasts exactly NREGS cycles after reset deassertion; ready rises on the following edge.
- INIT outputs and inputs:
  - rs_data forced to 0 and rs_busy forced to 0.
  - we and issue_valid are ignored.
- RUN:
  - clear_req==1 at a clock edge: next state INIT, ptr = 0, busy bits cleared.
  - clear_req during INIT restarts the fill from ptr = 0.
  - reset has priority over clear_req.
- Write, in RUN:
  - RF[rd] <= wdata on the edge when we==1.
  - Suppressed when ZERO_REG==1 and rd==0.
- Read, combinational:
  - rs_data[i] = RF[rs_addr[i]].
  - If BYPASS==1, we==1 and rd==rs_addr[i] (with rd!=0 when ZERO_REG==1), rs_data[i] = wdata instead.
  - ZERO_REG==1 and rs_addr[i]==0 gives 0 regardless of any write.
- Scoreboard, in RUN:
  - issue_valid sets busy[issue_rd]; ignored when issue_rd==0 and ZERO_REG==1.
  - we clears busy[rd].
  - Issue and write to the same register in the same cycle: set wins, so busy stays 1 (a new producer supersedes the old one).
  - Issue and write to different registers: both take effect.
- rs_busy[i]:
  - Equals busy[rs_addr[i]], except forced 0 when the BYPASS hit condition holds for port i.
  - With BYPASS==0 it is not masked by a same-cycle write.
- Multiple read ports may address the same register; all return identical data and busy.
- rd and issue_rd are full AW width; there is no wrap or out-of-range case.
- Latency:
  - Reads: 0 cycles.
  - Writes: visible via the array on the next cycle, or the same cycle via bypass.
  - Busy set: visible on the next cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - FSM state encoding (ST_INIT, ST_RUN);
  - the default XLEN and NREGS localparams;
  - the AW derivation function.
- One natural sub-module, rf_read_port, instantiated NRD times by generate. It contains the address mux, the bypass compare, zero-register forcing and busy masking for one port.
- The storage array, fill FSM and scoreboard stay in regfile_sb.

Test Plan:
1. Deassert reset with NREGS=32 -> ready=0 for exactly 32 cycles, then 1; every address reads 0 with rs_busy=0.
2. RUN, we=1, rd=5, wdata=0xDEADBEEF, rs_addr[0]=5 in the same cycle, BYPASS=1 -> rs_data[0]=0xDEADBEEF that cycle and after. With BYPASS=0 the same stimulus gives 0 that cycle and 0xDEADBEEF next cycle.
3. we=1, rd=0, wdata=0x1234; then read rs_addr=0 on all ports -> 0. Also issue_valid with issue_rd=0 -> rs_busy stays 0.
4. Issue rd=7, next cycle read rs_addr[1]=7 -> rs_busy[1]=1. Then same-cycle we rd=7 plus issue rd=7 -> busy remains 1. Then we rd=7 alone -> busy 0 next cycle.
5. Write 0xA5A5A5A5 to r3, pulse clear_req -> ready=0 for 32 cycles, then r3 reads 0. Pulse clear_req again at fill cycle 10 -> ready returns 32 cycles after the second pulse.
6. Assert reset mid-RUN while r9 is busy -> ready and busy drop immediately; we asserted during the following INIT has no effect and r9 reads 0 after the fill.
